// File: rtl/dpram_march_initiator_pkg.sv
// rtl/dpram_march_initiator_pkg.sv - shared types, defaults and pattern helper for the March initiator
package dpram_march_initiator_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, FINISH} state_t;
  typedef enum logic [1:0] {P0, P1, P2} phase_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  // Address-seeded data word; callers truncate the 32-bit result to their data width.
  function automatic logic [31:0] pat(input logic [31:0] pattern, input logic [31:0] addr);
    return pattern ^ addr;
  endfunction

endpackage

// File: rtl/dpram_march_initiator_if.sv
// rtl/dpram_march_initiator_if.sv - RD/WR/A/DIn/DOut/Done controller request bus
interface dpram_march_initiator_if
  import dpram_march_initiator_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DIn;
  logic [DATA_W-1:0] DOut;
  logic              Done;

  modport master (output RD, output WR, output A, output DIn, input DOut, input Done);
  modport slave  (input RD, input WR, input A, input DIn, output DOut, output Done);

endinterface

// File: rtl/dpram_march_initiator_req_watchdog.sv
// rtl/dpram_march_initiator_req_watchdog.sv - per-request completion watchdog
module dpram_march_initiator_req_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic ar,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Expired is asserted on the enabled cycle that brings the count to TIMEOUT.
  assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Count enabled cycles since the last clear; hold once expired.
  always_ff @(posedge clk) begin
    if (ar || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dpram_march_initiator.sv
// rtl/dpram_march_initiator.sv - three-phase March self-test initiator for the DPRAM controller
module dpram_march_initiator
  import dpram_march_initiator_pkg::*;
#(
  parameter int              ADDR_W  = ADDR_W_DEF,
  parameter int              DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(16'hA5C3),
  parameter int              TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    ar,
  input  logic                    start,
  dpram_march_initiator_if.master bus,
  output logic                    busy,
  output logic                    test_done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [ADDR_W-1:0]       fail_addr,
  output logic [DATA_W-1:0]       fail_data
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t            r_state;
  phase_t            r_phase;
  op_t               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_rd;
  logic              r_wr;
  logic              r_busy;
  logic              r_test_done;
  logic              r_pass;
  logic              r_fail;
  logic              r_timeout;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic [DATA_W-1:0] w_pat;
  logic [DATA_W-1:0] w_exp;
  logic              w_wd_clear;
  logic              w_wd_enable;
  logic              w_expired;

  // P1 reads expect the P0 pattern, P2 reads expect the inverted pattern written in P1.
  assign w_pat = DATA_W'(pat(32'(PATTERN), 32'(r_addr)));
  assign w_exp = (r_phase == P1) ? w_pat : ~w_pat;

  assign w_wd_clear  = (r_state == ISSUE);
  assign w_wd_enable = (r_state == WAIT) && !bus.Done;

  dpram_march_initiator_req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .ar       (ar),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expired(w_expired)
  );

  assign bus.RD    = r_rd;
  assign bus.WR    = r_wr;
  assign bus.A     = r_addr;
  assign bus.DIn   = r_din;
  assign busy      = r_busy;
  assign test_done = r_test_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_timeout;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

  // Test sequencer: issue one request, wait for Done or watchdog, then advance the March.
  always_ff @(posedge clk) begin
    if (ar) begin
      r_state     <= IDLE;
      r_phase     <= P0;
      r_op        <= OP_WR;
      r_addr      <= '0;
      r_din       <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_busy      <= 1'b0;
      r_test_done <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      case (r_state)
        IDLE, FINISH: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_test_done <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_phase     <= P0;
            r_op        <= OP_WR;
            r_addr      <= '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_rd <= (r_op == OP_RD);
          r_wr <= (r_op == OP_WR);
          if (r_op == OP_WR) begin
            r_din <= (r_phase == P0) ? w_pat : ~w_pat;
          end
          r_state <= WAIT;
        end
        WAIT: begin
          // Done takes priority over a watchdog expiry in the same cycle.
          if (bus.Done) begin
            if (r_op == OP_WR || bus.DOut == w_exp) begin
              r_state <= ADVANCE;
            end else begin
              r_fail      <= 1'b1;
              r_fail_addr <= r_addr;
              r_fail_data <= bus.DOut;
              r_busy      <= 1'b0;
              r_test_done <= 1'b1;
              r_state     <= FINISH;
            end
          end else if (w_expired) begin
            r_fail      <= 1'b1;
            r_timeout   <= 1'b1;
            r_fail_addr <= r_addr;
            r_fail_data <= '0;
            r_busy      <= 1'b0;
            r_test_done <= 1'b1;
            r_state     <= FINISH;
          end
        end
        ADVANCE: begin
          r_state <= ISSUE;
          case (r_phase)
            P0: begin
              if (r_addr == LAST) begin
                r_phase <= P1;
                r_addr  <= '0;
                r_op    <= OP_RD;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
            P1: begin
              if (r_op == OP_RD) begin
                r_op <= OP_WR;
              end else if (r_addr == LAST) begin
                r_phase <= P2;
                r_op    <= OP_RD;
              end else begin
                r_addr <= r_addr + 1'b1;
                r_op   <= OP_RD;
              end
            end
            default: begin
              if (r_addr == '0) begin
                r_pass      <= 1'b1;
                r_busy      <= 1'b0;
                r_test_done <= 1'b1;
                r_state     <= FINISH;
              end else begin
                r_addr <= r_addr - 1'b1;
              end
            end
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_march_initiator.sv
// tb/tb_dpram_march_initiator.sv - self-checking bench for dpram_march_initiator
module tb_dpram_march_initiator;
  import dpram_march_initiator_pkg::*;

  localparam int          AW  = 3;
  localparam int          DW  = 16;
  localparam int          D   = 8;
  localparam int          TO  = 64;
  localparam logic [15:0] PAT = 16'hA5C3;

  typedef struct {
    bit          wr;
    int          addr;
    logic [15:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          ar;
  logic          start;
  logic          busy;
  logic          test_done;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  dpram_march_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dpram_march_initiator #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .PATTERN(PAT),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .ar       (ar),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .test_done(test_done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout),
    .fail_addr(fail_addr),
    .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n_rd   = 0;
  int   n_wr   = 0;
  txn_t model[$];

  logic [15:0] mem [D];
  int          lat          = 1;
  bit          no_done      = 0;
  bit          corrupt_en   = 0;
  int          corrupt_addr = 5;
  int          spur_req     = 0;
  int          spur_ack     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat_of(input int a);
    return PAT ^ 16'(a);
  endfunction

  // Behavioural controller: memory array, Done after lat cycles, optional fault injection.
  initial begin : responder
    bit          pend;
    int          cnt;
    bit          p_rd;
    int          p_addr;
    logic [15:0] p_din;
    logic [15:0] d;
    pend = 0;
    cnt = 0;
    bus.Done = 1'b0;
    bus.DOut = '0;
    for (int k = 0; k < D; k++) mem[k] = '0;
    forever begin
      @(posedge clk);
      bus.Done <= 1'b0;
      if (bus.RD || bus.WR) begin
        pend   = 1;
        cnt    = lat;
        p_rd   = bus.RD;
        p_addr = int'(bus.A);
        p_din  = bus.DIn;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          if (!no_done) begin
            bus.Done <= 1'b1;
            if (p_rd) begin
              d = mem[p_addr];
              if (corrupt_en && p_addr == corrupt_addr && d == pat_of(p_addr)) d = d ^ 16'h0008;
              bus.DOut <= d;
            end else begin
              mem[p_addr] = p_din;
            end
          end
        end
      end
      if (spur_req != spur_ack) begin
        spur_ack++;
        bus.Done <= 1'b1;
        bus.DOut <= 16'hBEEF;
      end
    end
  end

  // Every request is checked against the next entry of the expected March sequence,
  // and A/DIn must stay put from the request until the cycle after Done.
  initial begin : compare
    bit            restart;
    bit            hold;
    bit            hold_clr;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    int            idx;
    hold = 0;
    hold_clr = 0;
    idx = 0;
    forever begin
      @(posedge clk);
      restart = ar || (start && !busy);
      @(negedge clk);
      if (restart) begin
        idx = 0;
        hold = 0;
        hold_clr = 0;
      end
      if (hold) begin
        chk("hold_A", 64'(bus.A), 64'(ha));
        chk("hold_DIn", 64'(bus.DIn), 64'(hd));
        if (hold_clr) begin
          hold = 0;
          hold_clr = 0;
        end else if (bus.Done) begin
          hold_clr = 1;
        end
      end
      if (bus.RD || bus.WR) begin
        chk("rd_wr_exclusive", 64'(bus.RD && bus.WR), 64'(0));
        if (idx >= model.size()) begin
          chk("unexpected_request", 64'(1), 64'(0));
        end else begin
          chk("req_op_is_wr", 64'(bus.WR), 64'(model[idx].wr));
          chk("req_addr", 64'(bus.A), 64'(model[idx].addr));
          if (bus.WR) chk("req_din", 64'(bus.DIn), 64'(model[idx].data));
          idx++;
        end
        if (bus.RD) n_rd++;
        else n_wr++;
        hold = 1;
        hold_clr = 0;
        ha = bus.A;
        hd = bus.DIn;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    i = 0;
    while (!test_done && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 64'(test_done), 64'(1));
  endtask

  task automatic chk_status(input string name, input logic p, input logic f, input logic t);
    chk({name, "_pass"}, 64'(pass), 64'(p));
    chk({name, "_fail"}, 64'(fail), 64'(f));
    chk({name, "_timeout"}, 64'(timeout), 64'(t));
    chk({name, "_test_done"}, 64'(test_done), 64'(1));
    chk({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin : main
    int r0;
    int w0;
    int i;

    for (int a = 0; a < D; a++) model.push_back('{1'b1, a, pat_of(a)});
    for (int a = 0; a < D; a++) begin
      model.push_back('{1'b0, a, pat_of(a)});
      model.push_back('{1'b1, a, ~pat_of(a)});
    end
    for (int a = D - 1; a >= 0; a--) model.push_back('{1'b0, a, ~pat_of(a)});

    ar = 1'b1;
    start = 1'b0;
    tick(3);
    chk("reset_flags", 64'({busy, test_done, pass, fail, timeout, bus.RD, bus.WR}), 64'(0));
    chk("reset_fail_addr", 64'(fail_addr), 64'(0));
    chk("reset_fail_data", 64'(fail_data), 64'(0));
    chk("reset_A_DIn", 64'({bus.A, bus.DIn}), 64'(0));
    ar = 1'b0;
    tick(2);
    chk("idle_busy", 64'(busy), 64'(0));

    // 1: clean run
    r0 = n_rd; w0 = n_wr;
    pulse_start();
    wait_done(1000, "t1_done");
    chk_status("t1", 1'b1, 1'b0, 1'b0);
    chk("t1_wr_count", 64'(n_wr - w0), 64'(16));
    chk("t1_rd_count", 64'(n_rd - r0), 64'(16));
    chk("t1_mem5", 64'(mem[5]), 64'(16'h5A39));

    // 2: DOut[3] flipped on the P1 read of address 5
    corrupt_en = 1;
    r0 = n_rd; w0 = n_wr;
    pulse_start();
    wait_done(1000, "t2_done");
    tick(20);
    chk_status("t2", 1'b0, 1'b1, 1'b0);
    chk("t2_fail_addr", 64'(fail_addr), 64'(5));
    chk("t2_fail_data", 64'(fail_data), 64'(16'hA5CE));
    chk("t2_req_count", 64'((n_wr - w0) + (n_rd - r0)), 64'(19));
    corrupt_en = 0;

    // 3: controller never completes
    no_done = 1;
    pulse_start();
    i = 0;
    while (!bus.WR && i < 20) begin
      tick(1);
      i++;
    end
    chk("t3_first_wr", 64'(bus.WR), 64'(1));
    chk("t3_first_addr", 64'(bus.A), 64'(0));
    tick(TO - 1);
    chk("t3_fail_before_limit", 64'(fail), 64'(0));
    tick(1);
    chk_status("t3", 1'b0, 1'b1, 1'b1);
    chk("t3_fail_addr", 64'(fail_addr), 64'(0));
    chk("t3_fail_data", 64'(fail_data), 64'(0));
    no_done = 0;

    // 6: restart after a failed run clears status
    pulse_start();
    chk("t6_clear_flags", 64'({test_done, pass, fail, timeout}), 64'(0));
    chk("t6_clear_data", 64'(fail_data), 64'(0));
    chk("t6_busy", 64'(busy), 64'(1));
    wait_done(1000, "t6_done");
    chk_status("t6", 1'b1, 1'b0, 1'b0);

    // 4a: start while busy is ignored
    r0 = n_rd; w0 = n_wr;
    pulse_start();
    i = 0;
    while ((n_rd - r0) < 3 && i < 500) begin
      tick(1);
      i++;
    end
    chk("t4_reach_p1", 64'((n_rd - r0) >= 3), 64'(1));
    pulse_start();
    wait_done(1000, "t4a_done");
    chk_status("t4a", 1'b1, 1'b0, 1'b0);
    chk("t4a_wr_count", 64'(n_wr - w0), 64'(16));
    chk("t4a_rd_count", 64'(n_rd - r0), 64'(16));

    // 4b: reset in the middle of P2
    r0 = n_rd;
    pulse_start();
    i = 0;
    while ((n_rd - r0) < 11 && i < 500) begin
      tick(1);
      i++;
    end
    chk("t4_reach_p2", 64'((n_rd - r0) >= 11), 64'(1));
    ar = 1'b1;
    tick(1);
    chk("t4_reset_flags", 64'({busy, test_done, pass, fail, timeout, bus.RD, bus.WR}), 64'(0));
    chk("t4_reset_addr_data", 64'({bus.A, bus.DIn, fail_addr, fail_data}), 64'(0));
    ar = 1'b0;
    r0 = n_rd; w0 = n_wr;
    tick(8);
    chk("t4_idle_after_reset", 64'({busy, test_done}), 64'(0));
    chk("t4_no_req_after_reset", 64'((n_rd - r0) + (n_wr - w0)), 64'(0));
    pulse_start();
    i = 0;
    while (!(bus.RD || bus.WR) && i < 10) begin
      tick(1);
      i++;
    end
    chk("t4_restart_wr", 64'(bus.WR), 64'(1));
    chk("t4_restart_addr", 64'(bus.A), 64'(0));
    wait_done(1000, "t4b_done");
    chk_status("t4b", 1'b1, 1'b0, 1'b0);

    // 5: spurious Done in FINISH and IDLE, then a slow controller
    r0 = n_rd; w0 = n_wr;
    spur_req++;
    tick(3);
    chk_status("t5_finish", 1'b1, 1'b0, 1'b0);
    ar = 1'b1;
    tick(1);
    ar = 1'b0;
    tick(1);
    spur_req++;
    tick(3);
    chk("t5_idle_flags", 64'({busy, test_done, pass, fail}), 64'(0));
    chk("t5_no_req", 64'((n_rd - r0) + (n_wr - w0)), 64'(0));
    lat = 5;
    pulse_start();
    wait_done(3000, "t5_done");
    chk_status("t5", 1'b1, 1'b0, 1'b0);
    chk("t5_req_count", 64'((n_rd - r0) + (n_wr - w0)), 64'(32));
    lat = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
